// File: rtl/gas_pkg.sv
// Shared constants for the gas signature serial line: gas-select codes,
// left-aligned signature patterns with their lengths, and the FSM state type.
package gas_pkg;

  localparam logic [1:0] GAS_CH4 = 2'd0;
  localparam logic [1:0] GAS_CO  = 2'd1;
  localparam logic [1:0] GAS_CO2 = 2'd2;
  localparam logic [1:0] GAS_RSV = 2'd3;

  // Patterns are left-aligned: bit 11 is sent first, unused low bits are 0.
  localparam logic [11:0] SIG_CH4 = 12'b1011101010_00;
  localparam logic [3:0]  LEN_CH4 = 4'd10;
  localparam logic [11:0] SIG_CO  = 12'b101010010011;
  localparam logic [3:0]  LEN_CO  = 4'd12;
  localparam logic [11:0] SIG_CO2 = 12'b100100100_000;
  localparam logic [3:0]  LEN_CO2 = 4'd9;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRE   = 2'd1,
    SIG   = 2'd2,
    GUARD = 2'd3
  } gas_state_e;

endpackage

// File: rtl/gas_signature_rom.sv
// Combinational lookup from gas select code to its signature pattern/length.
module gas_signature_rom
  import gas_pkg::*;
(
  input  logic [1:0]  gas_sel,
  output logic [11:0] pattern,
  output logic [3:0]  len
);

  // Reserved code maps to an empty pattern; the transmitter never selects it.
  always_comb begin
    pattern = 12'd0;
    len     = 4'd1;
    case (gas_sel)
      GAS_CH4: begin pattern = SIG_CH4; len = LEN_CH4; end
      GAS_CO:  begin pattern = SIG_CO;  len = LEN_CO;  end
      GAS_CO2: begin pattern = SIG_CO2; len = LEN_CO2; end
      default: begin pattern = 12'd0;   len = 4'd1;    end
    endcase
  end

endmodule

// File: rtl/gas_signature_tx.sv
// Serial transmitter: preamble zeros + gas signature per frame, repeated
// reps times, then a zero guard tail. All outputs registered.
// Handshake: start is a level sampled only while idle (busy=0, including the
// done cycle); there is no ready, a sampled start is always consumed.
module gas_signature_tx
  import gas_pkg::*;
#(
  parameter int PRE_ZEROS   = 4,
  parameter int GUARD_ZEROS = 4,
  parameter int REP_W       = 4
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             start,
  input  logic [1:0]       gas_sel,
  input  logic [REP_W-1:0] reps,
  output logic             dout,
  output logic             busy,
  output logic             sig_bit,
  output logic             done,
  output logic             err
);

  localparam int PRE_W = $clog2(PRE_ZEROS + 1);
  localparam int GRD_W = $clog2(GUARD_ZEROS + 1);

  gas_state_e       state;
  logic [1:0]       gas_q;
  logic [REP_W-1:0] frames;
  logic [3:0]       idx;
  logic [PRE_W-1:0] pre_cnt;
  logic [GRD_W-1:0] grd_cnt;

  logic [11:0]      pat;
  logic [3:0]       len;
  logic [11:0]      pat_next;

  gas_signature_rom u_rom (
    .gas_sel (gas_q),
    .pattern (pat),
    .len     (len)
  );

  // Pattern shifted so bit 11 is the signature bit following the current one.
  always_comb begin
    pat_next = pat << (idx + 4'd1);
  end

  // Burst sequencer; outputs are set for the state being entered.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state   <= IDLE;
      gas_q   <= '0;
      frames  <= '0;
      idx     <= '0;
      pre_cnt <= '0;
      grd_cnt <= '0;
      dout    <= 1'b0;
      busy    <= 1'b0;
      sig_bit <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          dout    <= 1'b0;
          sig_bit <= 1'b0;
          busy    <= 1'b0;
          if (start) begin
            if (gas_sel == GAS_RSV) begin
              err <= 1'b1;
            end else begin
              gas_q   <= gas_sel;
              frames  <= (reps == '0) ? REP_W'(1) : reps;
              pre_cnt <= '0;
              state   <= PRE;
              busy    <= 1'b1;
            end
          end
        end
        PRE: begin
          if (pre_cnt == PRE_W'(PRE_ZEROS - 1)) begin
            state   <= SIG;
            idx     <= '0;
            dout    <= pat[11];
            sig_bit <= 1'b1;
          end else begin
            pre_cnt <= pre_cnt + 1'b1;
            dout    <= 1'b0;
          end
        end
        SIG: begin
          if (idx == len - 4'd1) begin
            idx     <= '0;
            frames  <= frames - 1'b1;
            dout    <= 1'b0;
            sig_bit <= 1'b0;
            pre_cnt <= '0;
            grd_cnt <= '0;
            state   <= (frames == REP_W'(1)) ? GUARD : PRE;
          end else begin
            idx  <= idx + 4'd1;
            dout <= pat_next[11];
          end
        end
        GUARD: begin
          dout <= 1'b0;
          if (grd_cnt == GRD_W'(GUARD_ZEROS - 1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            grd_cnt <= grd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gas_signature_tx.sv
// Bench for gas_signature_tx: a per-cycle expected-output queue built from
// the signature strings, directed bursts with literal expectations, and a
// randomized stretch of start/gas_sel/reps traffic.
module tb_gas_signature_tx;

  localparam int PRE   = 4;
  localparam int GUARD = 4;

  logic       clk = 1'b0;
  logic       arst;
  logic       start;
  logic [1:0] gas_sel;
  logic [3:0] reps;
  logic       dout, busy, sig_bit, done, err;

  typedef struct packed {
    logic dout;
    logic sig_bit;
    logic busy;
    logic done;
    logic err;
  } exp_t;

  exp_t  exp_q[$];
  string sigs[3];

  int checks   = 0;
  int failures = 0;

  logic [63:0] cap;
  int          busy_cnt;
  int          done_cnt;

  gas_signature_tx #(.PRE_ZEROS(PRE), .GUARD_ZEROS(GUARD), .REP_W(4)) dut (
    .clk     (clk),
    .arst    (arst),
    .start   (start),
    .gas_sel (gas_sel),
    .reps    (reps),
    .dout    (dout),
    .busy    (busy),
    .sig_bit (sig_bit),
    .done    (done),
    .err     (err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: when idle and start is seen, queue the whole burst.
  task automatic model_accept();
    int r;
    if (exp_q.size() == 0 && start === 1'b1 && arst === 1'b0) begin
      if (gas_sel == 2'd3) begin
        exp_q.push_back('{dout:0, sig_bit:0, busy:0, done:0, err:1});
      end else begin
        r = (reps == 0) ? 1 : int'(reps);
        for (int f = 0; f < r; f++) begin
          for (int i = 0; i < PRE; i++)
            exp_q.push_back('{dout:0, sig_bit:0, busy:1, done:0, err:0});
          for (int i = 0; i < sigs[gas_sel].len(); i++)
            exp_q.push_back('{dout:(sigs[gas_sel][i] == "1"), sig_bit:1, busy:1, done:0, err:0});
        end
        for (int i = 0; i < GUARD; i++)
          exp_q.push_back('{dout:0, sig_bit:0, busy:1, done:0, err:0});
        exp_q.push_back('{dout:0, sig_bit:0, busy:0, done:1, err:0});
      end
    end
  endtask

  // One clock: update model from inputs, then compare at the falling edge.
  task automatic cycle();
    exp_t e;
    model_accept();
    @(negedge clk);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : exp_t'(0);
    chk("dout",    {63'd0, dout},    {63'd0, e.dout});
    chk("sig_bit", {63'd0, sig_bit}, {63'd0, e.sig_bit});
    chk("busy",    {63'd0, busy},    {63'd0, e.busy});
    chk("done",    {63'd0, done},    {63'd0, e.done});
    chk("err",     {63'd0, err},     {63'd0, e.err});
    if (busy === 1'b1) begin
      cap = {cap[62:0], dout};
      busy_cnt++;
    end
    if (done === 1'b1) done_cnt++;
  endtask

  task automatic clear_capture();
    cap      = '0;
    busy_cnt = 0;
    done_cnt = 0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      cycle();
      n++;
    end
    if (done_cnt == 0) begin
      failures++;
      checks++;
      $display("FAIL %s_timeout actual=no_done expected=done within %0d cycles", name, budget);
    end
  endtask

  // Driver: one burst with literal length/bit expectations.
  task automatic burst(input string name, input logic [1:0] g, input logic [3:0] r,
                       input int exp_busy, input logic [63:0] exp_bits, input bit chk_bits);
    clear_capture();
    start = 1'b1; gas_sel = g; reps = r;
    cycle();
    start = 1'b0;
    wait_done(name, 400);
    chk({name, "_busy_len"}, 64'(busy_cnt), 64'(exp_busy));
    chk({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    if (chk_bits) chk({name, "_bits"}, cap, exp_bits);
  endtask

  initial begin
    sigs[0] = "1011101010";
    sigs[1] = "101010010011";
    sigs[2] = "100100100";
    arst = 1'b1; start = 1'b0; gas_sel = 2'd0; reps = 4'd0;
    clear_capture();
    #2;
    chk("reset_dout", {63'd0, dout}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    @(negedge clk); @(negedge clk);
    arst = 1'b0;
    cycle();

    // Directed bursts with hand-written frames.
    burst("ch4_r1", 2'd0, 4'd1, 18, 64'b0000_1011101010_0000, 1'b1);
    burst("co_r2",  2'd1, 4'd2, 36, 64'b0000_101010010011_0000_101010010011_0000, 1'b1);
    burst("co2_r0", 2'd2, 4'd0, 17, 64'b0000_100100100_0000, 1'b1);
    burst("co2_r15", 2'd2, 4'd15, 199, 64'd0, 1'b0);
    cycle();

    // Reserved gas: one-cycle error, no burst.
    start = 1'b1; gas_sel = 2'd3; reps = 4'd2;
    cycle();
    start = 1'b0;
    chk("rsv_err", {63'd0, err}, 64'd1);
    chk("rsv_busy", {63'd0, busy}, 64'd0);
    cycle();
    chk("rsv_err_clear", {63'd0, err}, 64'd0);

    // Inputs ignored mid-burst, then start on the done cycle.
    clear_capture();
    start = 1'b1; gas_sel = 2'd0; reps = 4'd1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start = (i >= 2 && i < 8); gas_sel = 2'd2; reps = 4'd5;
      cycle();
    end
    start = 1'b0;
    wait_done("ignore", 100);
    chk("ignore_busy_len", 64'(busy_cnt), 64'd18);
    chk("ignore_bits", cap, 64'b0000_1011101010_0000);
    start = 1'b1; gas_sel = 2'd2; reps = 4'd1;
    cycle();
    start = 1'b0;
    chk("b2b_busy", {63'd0, busy}, 64'd1);
    clear_capture();
    wait_done("b2b", 100);
    chk("b2b_busy_len", 64'(busy_cnt), 64'd16);
    cycle();

    // Async reset in the middle of a CO signature.
    start = 1'b1; gas_sel = 2'd1; reps = 4'd1;
    cycle();
    start = 1'b0;
    for (int i = 0; i < 7; i++) cycle();
    chk("pre_rst_sig", {63'd0, sig_bit}, 64'd1);
    #2 arst = 1'b1;
    #1;
    chk("arst_dout", {63'd0, dout}, 64'd0);
    chk("arst_busy", {63'd0, busy}, 64'd0);
    chk("arst_sig",  {63'd0, sig_bit}, 64'd0);
    exp_q.delete();
    cycle();
    cycle();
    arst = 1'b0;
    cycle();
    burst("co_after_rst", 2'd1, 4'd1, 20, 64'b0000_101010010011_0000, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      start   = ($urandom_range(0, 3) == 0);
      gas_sel = 2'($urandom_range(0, 3));
      reps    = 4'($urandom_range(0, 15));
      cycle();
    end
    start = 1'b0;
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) cycle();
    chk("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
